// File: rtl/llc_input_sched_if.sv
// Handshake bundle between the LLC input queues, the input scheduler and the decode stage.
// The scheduler uses the slave modport; the queue/decode side uses master.
interface llc_input_sched_if;
    logic       rst_tb_valid;
    logic       rsp_valid;
    logic       req_valid;
    logic       dma_valid;
    logic       dma_burst;
    logic       dma_last;
    logic       req_stall;
    logic       out_ready;
    logic       grant_valid;
    logic [3:0] grant;
    logic [3:0] pop;
    logic       locked;
    logic [1:0] promoted;

    modport master (
        output rst_tb_valid, rsp_valid, req_valid, dma_valid,
        output dma_burst, dma_last, req_stall, out_ready,
        input  grant_valid, grant, pop, locked, promoted
    );

    modport slave (
        input  rst_tb_valid, rsp_valid, req_valid, dma_valid,
        input  dma_burst, dma_last, req_stall, out_ready,
        output grant_valid, grant, pop, locked, promoted
    );
endinterface

// File: rtl/llc_input_sched.sv
// Registered scheduler for the LLC input channels {dma,req,rsp,rst_tb} with req/dma aging and DMA burst lock.
// Optional grant/wait statistics are built when LLC_SCHED_STATS_EN is defined.
module llc_input_sched #(
    parameter  int STARVE_LIMIT = 8,
    localparam int AGE_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                clk,
    input  logic                rst,
    llc_input_sched_if.slave    bus
`ifdef LLC_SCHED_STATS_EN
    ,
    input  logic                stats_clr,
    output logic [127:0]        stats_grants,
    output logic [15:0]         stats_max_wait
`endif
);

    localparam logic [AGE_W-1:0] AGE_LIM = AGE_W'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_GRANT      = 2'd1,
        S_LOCK       = 2'd2,
        S_LOCK_GRANT = 2'd3
    } state_t;

    state_t           state_r;
    logic             grant_valid_r;
    logic [3:0]       grant_r;
    logic             locked_r;
    logic [AGE_W-1:0] age_req_r;
    logic [AGE_W-1:0] age_dma_r;

    logic             accept_s;
    logic             acc_req_s;
    logic             acc_dma_s;
    logic             elig_req_cur_s;
    logic             elig_dma_cur_s;
    logic             lock_next_s;
    logic             nel_rt_s;
    logic             nel_rsp_s;
    logic             nel_req_s;
    logic             nel_dma_s;
    logic             prom_req_s;
    logic             prom_dma_s;
    logic [3:0]       pick_s;
    logic             any_s;
    logic [3:0]       pop_s;

    // Saturating age update shared by req and dma.
    function automatic logic [AGE_W-1:0] age_step(input logic [AGE_W-1:0] age,
                                                 input logic             valid,
                                                 input logic             acc,
                                                 input logic             elig);
        if (!valid || acc) begin
            age_step = {AGE_W{1'b0}};
        end else if (elig && (age != AGE_LIM)) begin
            age_step = age + AGE_W'(1);
        end else begin
            age_step = age;
        end
    endfunction

    assign accept_s       = grant_valid_r & bus.out_ready;
    assign acc_req_s      = accept_s & grant_r[2];
    assign acc_dma_s      = accept_s & grant_r[3];
    assign pop_s          = grant_r & {4{accept_s}};
    assign elig_req_cur_s = bus.req_valid & ~bus.req_stall & ~locked_r;
    assign elig_dma_cur_s = bus.dma_valid & (locked_r | ~bus.req_stall);

    // Lock state that applies to the next arbitration: entered by an accepted first burst beat, left by the last.
    always_comb begin
        lock_next_s = locked_r;
        if (acc_dma_s) begin
            if (locked_r) begin
                lock_next_s = ~bus.dma_last;
            end else begin
                lock_next_s = bus.dma_burst & ~bus.dma_last;
            end
        end else begin
            lock_next_s = locked_r;
        end
    end

    assign nel_rt_s  = bus.rst_tb_valid & ~lock_next_s;
    assign nel_rsp_s = bus.rsp_valid;
    assign nel_req_s = bus.req_valid & ~bus.req_stall & ~lock_next_s;
    assign nel_dma_s = bus.dma_valid & (lock_next_s | ~bus.req_stall);
    // A requester accepted this cycle has its age cleared, so its stale promotion must not win again.
    assign prom_req_s = (age_req_r == AGE_LIM) & ~acc_req_s & nel_req_s;
    assign prom_dma_s = (age_dma_r == AGE_LIM) & ~acc_dma_s & nel_dma_s;

    // Fixed-priority pick with promoted requesters ahead of plain req/dma.
    always_comb begin
        pick_s = 4'b0000;
        if (nel_rt_s) begin
            pick_s = 4'b0001;
        end else if (nel_rsp_s) begin
            pick_s = 4'b0010;
        end else if (prom_req_s && prom_dma_s) begin
            pick_s = (age_dma_r > age_req_r) ? 4'b1000 : 4'b0100;
        end else if (prom_req_s) begin
            pick_s = 4'b0100;
        end else if (prom_dma_s) begin
            pick_s = 4'b1000;
        end else if (nel_req_s) begin
            pick_s = 4'b0100;
        end else if (nel_dma_s) begin
            pick_s = 4'b1000;
        end else begin
            pick_s = 4'b0000;
        end
    end

    assign any_s = |pick_s;

    // Scheduler FSM: loads a new grant when idle or on accept, otherwise holds the presented grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r       <= S_IDLE;
            grant_valid_r <= 1'b0;
            grant_r       <= 4'b0000;
            locked_r      <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE, S_LOCK: begin
                    grant_valid_r <= any_s;
                    grant_r       <= pick_s;
                    locked_r      <= lock_next_s;
                    state_r       <= any_s ? (lock_next_s ? S_LOCK_GRANT : S_GRANT)
                                           : (lock_next_s ? S_LOCK : S_IDLE);
                end
                S_GRANT, S_LOCK_GRANT: begin
                    if (accept_s) begin
                        grant_valid_r <= any_s;
                        grant_r       <= pick_s;
                        locked_r      <= lock_next_s;
                        state_r       <= any_s ? (lock_next_s ? S_LOCK_GRANT : S_GRANT)
                                               : (lock_next_s ? S_LOCK : S_IDLE);
                    end
                end
                default: begin
                    state_r       <= S_IDLE;
                    grant_valid_r <= 1'b0;
                    grant_r       <= 4'b0000;
                    locked_r      <= 1'b0;
                end
            endcase
        end
    end

    // Age counters for the two starvation-protected requesters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            age_req_r <= {AGE_W{1'b0}};
            age_dma_r <= {AGE_W{1'b0}};
        end else begin
            age_req_r <= age_step(age_req_r, bus.req_valid, acc_req_s, elig_req_cur_s);
            age_dma_r <= age_step(age_dma_r, bus.dma_valid, acc_dma_s, elig_dma_cur_s);
        end
    end

    assign bus.grant_valid = grant_valid_r;
    assign bus.grant       = grant_r;
    assign bus.pop         = pop_s;
    assign bus.locked      = locked_r;
    assign bus.promoted    = {age_dma_r == AGE_LIM, age_req_r == AGE_LIM};

`ifdef LLC_SCHED_STATS_EN
    logic [31:0] cnt_r [4];
    logic [15:0] max_wait_r;
    logic [15:0] max_age_s;

    assign max_age_s = (age_dma_r > age_req_r) ? 16'(age_dma_r) : 16'(age_req_r);

    // Per-channel accept counters and worst observed age, cleared by stats_clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= 32'd0;
            end
            max_wait_r <= 16'd0;
        end else if (stats_clr) begin
            for (int i = 0; i < 4; i++) begin
                cnt_r[i] <= 32'd0;
            end
            max_wait_r <= 16'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (pop_s[i]) begin
                    cnt_r[i] <= cnt_r[i] + 32'd1;
                end
            end
            if (max_age_s > max_wait_r) begin
                max_wait_r <= max_age_s;
            end
        end
    end

    assign stats_grants   = {cnt_r[3], cnt_r[2], cnt_r[1], cnt_r[0]};
    assign stats_max_wait = max_wait_r;
`endif

endmodule
